// File: rtl/qam_mod_pkg.sv
// Shared types, widths and Gray level tables for the multi-mode QAM modulator.
package qam_mod_pkg;

  localparam int COS_W   = 8;
  localparam int LEVEL_W = 4;
  localparam int SUM_W   = 13;
  localparam int PROD_W  = LEVEL_W + COS_W;

  typedef enum logic [1:0] {
    MODE_QPSK  = 2'd0,
    MODE_QAM16 = 2'd1,
    MODE_QAM64 = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic signed [LEVEL_W-1:0] level_t;

  function automatic level_t qpsk_level(input logic g);
    return g ? level_t'(6) : level_t'(-6);
  endfunction

  function automatic level_t qam16_level(input logic [1:0] g);
    case (g)
      2'b00:   return level_t'(-6);
      2'b01:   return level_t'(-2);
      2'b11:   return level_t'(2);
      default: return level_t'(6);
    endcase
  endfunction

  function automatic level_t qam64_level(input logic [2:0] g);
    case (g)
      3'b000:  return level_t'(-7);
      3'b001:  return level_t'(-5);
      3'b011:  return level_t'(-3);
      3'b010:  return level_t'(-1);
      3'b110:  return level_t'(1);
      3'b111:  return level_t'(3);
      3'b101:  return level_t'(5);
      default: return level_t'(7);
    endcase
  endfunction

endpackage

// File: rtl/qam_mod_param_if.sv
// Symbol input handshake and passband sample output of the QAM modulator.
interface qam_mod_param_if #(
  parameter int LUT_AW = 8,
  parameter int DATA_W = 10
);
  logic [1:0]               mode;
  logic [LUT_AW-1:0]        carrier_inc;
  logic                     sym_valid;
  logic [5:0]               sym_data;
  logic                     sym_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     err_mode;

  modport master (
    output mode, carrier_inc, sym_valid, sym_data,
    input  sym_ready, out_valid, out_data, err_mode
  );

  modport slave (
    input  mode, carrier_inc, sym_valid, sym_data,
    output sym_ready, out_valid, out_data, err_mode
  );
endinterface

// File: rtl/qam_carrier_nco.sv
// Phase accumulator with a quarter-wave cos/sin table, registered (1-cycle) read.
module qam_carrier_nco
  import qam_mod_pkg::*;
#(
  parameter int LUT_AW = 8
) (
  input  logic                    axi_clk,
  input  logic                    clear,
  input  logic                    advance,
  input  logic [LUT_AW-1:0]       inc,
  output logic signed [COS_W-1:0] cos_val,
  output logic signed [COS_W-1:0] sin_val
);

  localparam int QN    = 1 << (LUT_AW - 2);
  localparam int IDX_W = LUT_AW - 1;

  // round(127 * sin(k*pi/(2*qn))) via an integer Taylor series in Q30, so the
  // table is built at elaboration without real-valued math.
  function automatic int quarter_sine(input int k, input int qn);
    longint x, x2, term, acc;
    x    = (64'sd3373259426 * longint'(k)) / longint'(2 * qn);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return int'((acc * 127 + (64'sd1 <<< 29)) >>> 30);
  endfunction

  function automatic logic [IDX_W-1:0] fold(input logic [LUT_AW-1:0] p);
    logic [IDX_W-1:0] a;
    a = {1'b0, p[LUT_AW-3:0]};
    return p[LUT_AW-2] ? IDX_W'(QN) - a : a;
  endfunction

  logic signed [COS_W-1:0] qtab [QN+1];

  for (genvar g = 0; g <= QN; g++) begin : g_tab
    localparam int VAL = quarter_sine(g, QN);
    assign qtab[g] = COS_W'(VAL);
  end

  logic [LUT_AW-1:0]       phase;
  logic [LUT_AW-1:0]       cos_phase;
  logic [IDX_W-1:0]        sin_idx, cos_idx;
  logic signed [COS_W-1:0] sin_c, cos_c;

  // cos(p) is read as sin(p + quarter turn).
  always_comb begin
    cos_phase = phase + LUT_AW'(QN);
    sin_idx   = fold(phase);
    cos_idx   = fold(cos_phase);
    sin_c     = phase[LUT_AW-1]     ? -qtab[sin_idx] : qtab[sin_idx];
    cos_c     = cos_phase[LUT_AW-1] ? -qtab[cos_idx] : qtab[cos_idx];
  end

  always_ff @(posedge axi_clk) begin
    if (clear) begin
      phase   <= '0;
      cos_val <= '0;
      sin_val <= '0;
    end else begin
      cos_val <= cos_c;
      sin_val <= sin_c;
      if (advance) phase <= phase + inc;
    end
  end

endmodule

// File: rtl/qam_mod_param.sv
// Multi-mode QAM modulator: Gray level map, SPS-sample hold, carrier mix I*cos - Q*sin.
module qam_mod_param
  import qam_mod_pkg::*;
#(
  parameter int SPS    = 128,
  parameter int LUT_AW = 8,
  parameter int DATA_W = 10
) (
  input logic           axi_clk,
  input logic           axi_rst,
  qam_mod_param_if.slave bus
);

  localparam int CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
  localparam int SHIFT = SUM_W - DATA_W;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rdy, accept, run;

  mode_e             mode_q;
  logic [5:0]        sym_q;
  logic [LUT_AW-1:0] inc_q;

  assign run           = (state == ST_RUN);
  assign bus.sym_ready = rdy;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdy     = 1'b0;
    case (state)
      ST_IDLE: rdy = 1'b1;
      ST_RUN: begin
        if (cnt == CNT_LAST) begin
          rdy     = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (axi_rst) rdy = 1'b0;
    accept = bus.sym_valid && rdy;
    if (accept) begin
      state_n = ST_RUN;
      cnt_n   = '0;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      mode_q <= MODE_QPSK;
      sym_q  <= '0;
      inc_q  <= '0;
    end else if (accept) begin
      mode_q <= mode_e'(bus.mode);
      sym_q  <= bus.sym_data;
      inc_q  <= bus.carrier_inc;
    end
  end

  level_t lvl_i, lvl_q;

  // Upper half of the used bits drives I, lower half drives Q; reserved mode is silent.
  always_comb begin
    lvl_i = '0;
    lvl_q = '0;
    case (mode_q)
      MODE_QPSK: begin
        lvl_i = qpsk_level(sym_q[1]);
        lvl_q = qpsk_level(sym_q[0]);
      end
      MODE_QAM16: begin
        lvl_i = qam16_level(sym_q[3:2]);
        lvl_q = qam16_level(sym_q[1:0]);
      end
      MODE_QAM64: begin
        lvl_i = qam64_level(sym_q[5:3]);
        lvl_q = qam64_level(sym_q[2:0]);
      end
      default: ;
    endcase
  end

  logic signed [COS_W-1:0] cos_s1, sin_s1;

  qam_carrier_nco #(.LUT_AW(LUT_AW)) u_nco (
    .axi_clk (axi_clk),
    .clear   (axi_rst),
    .advance (run),
    .inc     (inc_q),
    .cos_val (cos_s1),
    .sin_val (sin_s1)
  );

  logic                     s1_valid, s2_valid, s3_valid, err_q;
  level_t                   lvl_i_s1, lvl_q_s1;
  logic signed [PROD_W-1:0] prod_i, prod_q;
  logic signed [SUM_W-1:0]  diff;
  logic signed [DATA_W-1:0] out_q;

  assign diff = SUM_W'(prod_i) - SUM_W'(prod_q);

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      err_q    <= 1'b0;
      lvl_i_s1 <= '0;
      lvl_q_s1 <= '0;
      prod_i   <= '0;
      prod_q   <= '0;
      out_q    <= '0;
    end else begin
      s1_valid <= run;
      lvl_i_s1 <= lvl_i;
      lvl_q_s1 <= lvl_q;
      err_q    <= run && (cnt == '0) && (mode_q == MODE_RSVD);
      s2_valid <= s1_valid;
      prod_i   <= PROD_W'(lvl_i_s1) * PROD_W'(cos_s1);
      prod_q   <= PROD_W'(lvl_q_s1) * PROD_W'(sin_s1);
      s3_valid <= s2_valid;
      out_q    <= s2_valid ? DATA_W'(diff >>> SHIFT) : '0;
    end
  end

  assign bus.out_valid = s3_valid;
  assign bus.out_data  = out_q;
  assign bus.err_mode  = err_q;

endmodule

// File: doc/qam_mod_param.md
# qam_mod_param

Parametrised multi-mode QAM modulator, the next generation of `qam_mod_top`. It accepts one symbol per valid/ready handshake in QPSK, 16-QAM or 64-QAM. Each symbol is Gray-mapped to I/Q levels and held for `SPS` samples while being mixed onto a phase-continuous carrier. The result is a single real passband stream, `out = I·cos − Q·sin`, which feeds the DAC path.

## Interface
- `SPS`, 128: samples per symbol; legal range 2..4096.
- `LUT_AW`, 8: phase accumulator and full-wave phase width; legal range 4..12.
- `DATA_W`, 10: output sample width; legal range 8..13.
- `axi_clk` in 1: sole clock.
- `axi_rst` in 1: synchronous active-high reset.
- `mode` in 2: 0 = QPSK, 1 = 16-QAM, 2 = 64-QAM, 3 = reserved. Sampled at symbol acceptance.
- `carrier_inc` in LUT_AW: phase increment per sample. Sampled at symbol acceptance.
- `sym_valid` in 1: symbol offered.
- `sym_data` in 6: symbol bits. QPSK uses [1:0], 16-QAM uses [3:0], 64-QAM uses [5:0]. Unused upper bits are ignored.
- `sym_ready` out 1: symbol accepted on any edge where `sym_valid && sym_ready`.
- `out_valid` out 1: `out_data` is a valid sample.
- `out_data` out DATA_W signed: passband sample.
- `err_mode` out 1: one-cycle pulse when a mode-3 symbol is accepted.

## Operation
- **Per-axis split:** the upper half of the used bits maps to I, the lower half to Q.
- **QPSK Gray map:** 0 → −6, 1 → +6.
- **16-QAM Gray map:** 00 → −6, 01 → −2, 11 → +2, 10 → +6.
- **64-QAM Gray map:** 000 → −7, 001 → −5, 011 → −3, 010 → −1, 110 → +1, 111 → +3, 101 → +5, 100 → +7.
- **Reserved mode:** mode 3 gives I = Q = 0 for the whole symbol and pulses `err_mode`. The symbol still occupies `SPS` samples.
- **FSM states:** IDLE and RUN.
  - IDLE: `sym_ready` = 1. On accept, go to RUN with sample counter = 0.
  - RUN: the counter counts 0..SPS−1. `sym_ready` = 1 only while counter == SPS−1.
  - At counter == SPS−1, an accept loads the next symbol with no gap and counter → 0.
  - At counter == SPS−1 without an accept, go to IDLE (underrun).
- **Carrier phase:** the phase accumulator advances by the latched `carrier_inc` once per RUN sample, modulo 2^LUT_AW. It holds in IDLE, so phase stays continuous across gaps and symbols.
- **Carrier LUT:** quarter-wave table with amplitude 127, COS_W = 8 signed. Phase 0 gives cos = 127, sin = 0.
- **Arithmetic widths:**
  - Level is 4-bit signed; each product is 12-bit signed.
  - The difference is 13-bit signed, with maximum magnitude 1778.
  - `out_data` = difference >>> (13 − DATA_W), arithmetic floor. This cannot overflow, so there is no saturation.
- **Reset:** with `axi_rst` high at an edge, the FSM goes to IDLE and phase, counter and pipeline are cleared.
- **Reset mid-symbol:** the current symbol is discarded and in-flight samples are dropped. No further `out_valid` appears until a new accept.

## Timing
- **Reset values:** `sym_ready` = 0 while `axi_rst` is high. `out_valid` = 0, `out_data` = 0, `err_mode` = 0.
- **After reset:** `sym_ready` = 1 on the first cycle after `axi_rst` falls.
- **Pipeline:** 3 stages — (1) level map and LUT read, (2) multiply, (3) subtract and shift.
- **First sample:** a symbol accepted at edge k produces its first `out_valid` at edge k+3.
- **Sustained output:** with back-to-back symbols, `out_valid` stays high continuously.
- **Idle output:** while not valid, `out_data` = 0.
- **`err_mode`:** asserted at edge k+1 for exactly one cycle.

## Structure
- **Package `qam_mod_pkg`:**
  - mode enum;
  - COS_W = 8, LEVEL_W = 4, SUM_W = 13;
  - the three Gray level tables as functions;
  - the FSM state typedef.
- **Sub-module `qam_carrier_nco`:** phase accumulator plus quarter-wave cos/sin LUT, with 1-cycle read latency and hold/advance and clear inputs.

## Test plan
- **Reset release:** hold `axi_rst` 10 cycles, then release → `out_valid` = 0 and `out_data` = 0 throughout; `sym_ready` = 1 one cycle after release.
- **16-QAM single symbol:** mode 1, `sym_data` = 4'b1010, phase 0, accepted at edge k → I = Q = +6. First sample at k+3 is 762 >>> 3 = 95. `out_valid` stays high exactly SPS cycles.
- **64-QAM corner:** mode 2, `sym_data` = 6'b100000 → first sample 889 >>> 3 = 111.
- **Back-to-back:** SPS = 4, three consecutive accepts → `out_valid` continuous for 12 cycles. `sym_ready` pulses only at counter 3. Phase continues with no discontinuity.
- **Underrun and resume:** SPS = 4, `carrier_inc` = 16, one symbol, 5 idle cycles, then a second symbol → `out_valid` drops for the gap. The second symbol starts at phase 64.
- **Reserved mode and mid-symbol reset:**
  - Mode 3 → `err_mode` pulses once and the SPS samples are 0.
  - Assert `axi_rst` at sample 2 of a symbol → outputs clear next cycle and the remaining samples never appear.
